// File: rtl/sar_afe_model_if.sv
`default_nettype none
// ============================================================================
// Module   : sar_afe_model_if
// Purpose  : Signal bundle between a SAR controller and the analog front-end
//            stand-in (sample/hold, capacitive DAC, comparator).
// Ports    : start, vin, bitctrl  - driven by the controller/stimulus side
//            comp, comp_valid,
//            held, acq_busy,
//            ovr_err              - driven by the front-end model
// Modports : master (controller side), slave (front-end side)
// Revision : 1.0 - initial release
// ============================================================================
interface sar_afe_model_if #(
  parameter int NBITS = 10
);
  logic             start;
  logic [NBITS-1:0] vin;
  logic [NBITS-1:0] bitctrl;
  logic             comp;
  logic             comp_valid;
  logic [NBITS-1:0] held;
  logic             acq_busy;
  logic             ovr_err;

  modport master (
    output start, vin, bitctrl,
    input  comp, comp_valid, held, acq_busy, ovr_err
  );

  modport slave (
    input  start, vin, bitctrl,
    output comp, comp_valid, held, acq_busy, ovr_err
  );
endinterface
`default_nettype wire

// File: rtl/sar_afe_model.sv
`default_nettype none
// ============================================================================
// Module   : sar_afe_model
// Purpose  : Cycle-accurate digital stand-in for a SAR ADC analog front end.
//            Tracks vin during acquisition, freezes it in HOLD, and answers
//            the controller's trial code with a registered comparator
//            decision once the emulated DAC has settled.
// Ports    : clk      - rising-edge clock
//            reset_n  - asynchronous active-low reset
//            bus      - sar_afe_model_if.slave
//                       in : start, vin, bitctrl
//                       out: comp, comp_valid, held, acq_busy, ovr_err
// Revision : 1.0 - initial release
// ============================================================================
module sar_afe_model #(
  parameter int NBITS         = 10,
  parameter int ACQ_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 1,
  parameter int OFFSET        = 0
) (
  input  wire logic         clk,
  input  wire logic         reset_n,
  sar_afe_model_if.slave    bus
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_acq  = 2'd1;
  localparam logic [1:0] c_hold = 2'd2;

  localparam int c_acq_w    = (ACQ_CYCLES > 1) ? $clog2(ACQ_CYCLES) : 1;
  localparam int c_settle_w = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  localparam logic [c_acq_w-1:0]    c_acq_load    = c_acq_w'(ACQ_CYCLES - 1);
  localparam logic [c_settle_w-1:0] c_settle_load = c_settle_w'(SETTLE_CYCLES);
  localparam logic signed [NBITS+1:0] c_offset    = (NBITS+2)'(OFFSET);

  logic [1:0]            r_state;
  logic [c_acq_w-1:0]    r_acq_cnt;
  logic [c_settle_w-1:0] r_settle_cnt;
  logic [NBITS-1:0]      r_bitctrl_q;
  logic [NBITS-1:0]      r_held;
  logic                  r_comp;
  logic                  r_comp_valid;
  logic                  r_ovr_err;

  logic                  w_chg;
  logic signed [NBITS+1:0] w_diff;
  logic                  w_cmp;

  // Two guard bits keep held - bitctrl - OFFSET from wrapping, so the sign
  // bit alone decides the comparison.
  assign w_chg  = (bus.bitctrl != r_bitctrl_q);
  assign w_diff = $signed({2'b00, r_held}) - $signed({2'b00, r_bitctrl_q}) - c_offset;
  assign w_cmp  = ~w_diff[NBITS+1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= c_idle;
      r_acq_cnt    <= '0;
      r_settle_cnt <= '0;
      r_bitctrl_q  <= '0;
      r_held       <= '0;
      r_comp       <= 1'b0;
      r_comp_valid <= 1'b0;
      r_ovr_err    <= 1'b0;
    end else begin
      r_bitctrl_q <= bus.bitctrl;
      case (r_state)
        c_idle: begin
          if (bus.start) begin
            r_state   <= c_acq;
            r_acq_cnt <= c_acq_load;
          end
        end
        c_acq: begin
          r_held       <= bus.vin;
          r_comp       <= 1'b0;
          r_comp_valid <= 1'b0;
          // A second strobe mid-acquisition is flagged but never restarts.
          if (bus.start) begin
            r_ovr_err <= 1'b1;
          end
          if (r_acq_cnt == '0) begin
            // Entering HOLD behaves like a fresh DAC code change.
            r_state      <= c_hold;
            r_settle_cnt <= c_settle_load;
          end else begin
            r_acq_cnt <= r_acq_cnt - 1'b1;
          end
        end
        c_hold: begin
          if (bus.start) begin
            r_state      <= c_acq;
            r_acq_cnt    <= c_acq_load;
            r_comp       <= 1'b0;
            r_comp_valid <= 1'b0;
          end else if (w_chg) begin
            // comp keeps its old value; only the valid flag drops.
            r_settle_cnt <= c_settle_load;
            r_comp_valid <= 1'b0;
          end else if (r_settle_cnt != '0) begin
            r_settle_cnt <= r_settle_cnt - 1'b1;
          end else begin
            r_comp       <= w_cmp;
            r_comp_valid <= 1'b1;
          end
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

  assign bus.comp       = r_comp;
  assign bus.comp_valid = r_comp_valid;
  assign bus.held       = r_held;
  assign bus.acq_busy   = (r_state == c_acq);
  assign bus.ovr_err    = r_ovr_err;

endmodule
`default_nettype wire

// File: tb/tb_sar_afe_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_sar_afe_model
// Purpose  : Self-checking bench for sar_afe_model. Three instances share one
//            stimulus and differ only in comparator offset (0, +1, -1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sar_afe_model;

  localparam int NB  = 10;
  localparam int ACQ = 2;
  localparam int STL = 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [NB-1:0] vin = '0;
  logic [NB-1:0] bitctrl = '0;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic e0;
    logic e1;
    logic e2;
  } exp_t;

  typedef struct {
    logic [NB-1:0] vin;
    logic [NB-1:0] bc;
    logic          e0;
    logic          e1;
    logic          e2;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[10];

  sar_afe_model_if #(.NBITS(NB)) bus0 ();
  sar_afe_model_if #(.NBITS(NB)) bus1 ();
  sar_afe_model_if #(.NBITS(NB)) bus2 ();

  assign bus0.start = start;  assign bus0.vin = vin;  assign bus0.bitctrl = bitctrl;
  assign bus1.start = start;  assign bus1.vin = vin;  assign bus1.bitctrl = bitctrl;
  assign bus2.start = start;  assign bus2.vin = vin;  assign bus2.bitctrl = bitctrl;

  sar_afe_model #(.NBITS(NB), .ACQ_CYCLES(ACQ), .SETTLE_CYCLES(STL), .OFFSET(0))
    u_dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
  sar_afe_model #(.NBITS(NB), .ACQ_CYCLES(ACQ), .SETTLE_CYCLES(STL), .OFFSET(1))
    u_dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
  sar_afe_model #(.NBITS(NB), .ACQ_CYCLES(ACQ), .SETTLE_CYCLES(STL), .OFFSET(-1))
    u_dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Pulse start, count acquisition cycles, then confirm the held sample.
  task automatic convert(input logic [NB-1:0] v, input string nm);
    int busy;
    busy  = 0;
    vin   = v;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 0; n < 20 && bus0.acq_busy; n++) begin
      busy++;
      step();
    end
    check({nm, "_acq"}, busy, ACQ);
    check({nm, "_held"}, bus0.held, v);
  endtask

  // Wait (bounded) for a settled decision and compare it against the
  // oldest scoreboard entry.
  task automatic wait_result(input string nm);
    exp_t e;
    bit   got;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      step();
      if (bus0.comp_valid) got = 1'b1;
    end
    if (sb_q.size() == 0) begin
      check({nm, "_sb_empty"}, 0, 1);
    end else begin
      e = sb_q.pop_front();
      if (!got) begin
        check({nm, "_timeout"}, 0, 1);
      end else begin
        check({nm, "_c0"}, bus0.comp, e.e0);
        check({nm, "_c1"}, bus1.comp, e.e1);
        check({nm, "_c2"}, bus2.comp, e.e2);
      end
    end
  endtask

  function automatic exp_t model(input logic [NB-1:0] h, input logic [NB-1:0] bc);
    exp_t e;
    e.e0 = (int'(h) >= int'(bc));
    e.e1 = (int'(h) >= int'(bc) + 1);
    e.e2 = (int'(h) >= int'(bc) - 1);
    return e;
  endfunction

  task automatic sar_run(input logic [NB-1:0] v, input string nm);
    logic [NB-1:0] code;
    logic [NB-1:0] trial;
    convert(v, nm);
    code = '0;
    for (int i = NB - 1; i >= 0; i--) begin
      trial   = code | (10'd1 << i);
      bitctrl = trial;
      sb_q.push_back(model(v, trial));
      wait_result($sformatf("%s_b%0d", nm, i));
      if (bus0.comp) code = trial;
    end
    check({nm, "_code"}, code, v);
  endtask

  initial begin
    tbl[0] = '{10'd600,  10'd512,  1'b1, 1'b1, 1'b1};
    tbl[1] = '{10'd600,  10'd768,  1'b0, 1'b0, 1'b0};
    tbl[2] = '{10'd512,  10'd512,  1'b1, 1'b0, 1'b1};
    tbl[3] = '{10'd512,  10'd513,  1'b0, 1'b0, 1'b1};
    tbl[4] = '{10'd0,    10'd0,    1'b1, 1'b0, 1'b1};
    tbl[5] = '{10'd1023, 10'd1023, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{10'd0,    10'd1023, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{10'd1023, 10'd0,    1'b1, 1'b1, 1'b1};
    tbl[8] = '{10'd300,  10'd299,  1'b1, 1'b1, 1'b1};
    tbl[9] = '{10'd300,  10'd301,  1'b0, 1'b0, 1'b1};

    // Reset state
    step();
    step();
    check("rst_comp",   bus0.comp,       0);
    check("rst_valid",  bus0.comp_valid, 0);
    check("rst_held",   bus0.held,       0);
    check("rst_busy",   bus0.acq_busy,   0);
    check("rst_ovr",    bus0.ovr_err,    0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("idle_busy", bus0.acq_busy, 0);

    // Basic conversion and settle latency
    convert(10'd600, "t1");
    bitctrl = 10'd512;
    step();
    step();
    check("t1_512_early", bus0.comp_valid, 0);
    step();
    check("t1_512_valid", bus0.comp_valid, 1);
    check("t1_512_comp",  bus0.comp,       1);
    bitctrl = 10'd768;
    step();
    check("t1_768_comp_hold", bus0.comp, 1);
    step();
    check("t1_768_early", bus0.comp_valid, 0);
    step();
    check("t1_768_valid", bus0.comp_valid, 1);
    check("t1_768_comp",  bus0.comp,       0);

    // Table of held/bitctrl/offset cases
    for (int k = 0; k < 10; k++) begin
      convert(tbl[k].vin, $sformatf("vec%0d", k));
      bitctrl = tbl[k].bc;
      sb_q.push_back('{tbl[k].e0, tbl[k].e1, tbl[k].e2});
      wait_result($sformatf("vec%0d", k));
    end

    // Full successive-approximation loops
    sar_run(10'h2AB, "sar2ab");
    sar_run(10'h000, "sar000");
    sar_run(10'h3FF, "sar3ff");

    // Continuous bitctrl churn keeps comp_valid low
    for (int i = 0; i < 8; i++) begin
      bitctrl = (i % 2 == 0) ? 10'd200 : 10'd100;
      step();
      check($sformatf("t4_churn%0d", i), bus0.comp_valid, 0);
    end
    step();
    check("t4_after1", bus0.comp_valid, 0);
    step();
    check("t4_after2", bus0.comp_valid, 1);
    check("t4_comp",   bus0.comp,       1);

    // start and a bitctrl change in the same HOLD cycle: start wins
    start   = 1'b1;
    bitctrl = 10'd300;
    vin     = 10'd77;
    step();
    start = 1'b0;
    check("t7_busy",  bus0.acq_busy,   1);
    check("t7_valid", bus0.comp_valid, 0);
    for (int n = 0; n < 20 && bus0.acq_busy; n++) step();
    check("t7_held", bus0.held, 77);
    check("t7_ovr",  bus0.ovr_err, 0);

    // start during ACQ: no restart, sticky overrun; held tracks vin
    vin   = 10'd100;
    start = 1'b1;
    step();
    vin = 10'd200;
    step();
    check("t5_track", bus0.held, 200);
    start = 1'b0;
    vin   = 10'd300;
    step();
    check("t5_norestart", bus0.acq_busy, 0);
    check("t5_ovr",       bus0.ovr_err,  1);
    check("t5_held",      bus0.held,     300);
    convert(10'd450, "t5b");
    check("t5b_ovr", bus0.ovr_err, 1);

    // Asynchronous reset in HOLD with a valid decision
    bitctrl = 10'd5;
    sb_q.push_back(model(10'd450, 10'd5));
    wait_result("t6_pre");
    #3;
    reset_n = 1'b0;
    #1;
    check("t6_comp",  bus0.comp,       0);
    check("t6_valid", bus0.comp_valid, 0);
    check("t6_held",  bus0.held,       0);
    check("t6_busy",  bus0.acq_busy,   0);
    check("t6_ovr",   bus0.ovr_err,    0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    step();
    check("t6_idle_busy", bus0.acq_busy, 0);
    check("t6_idle_held", bus0.held,     0);
    convert(10'd321, "t6_post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
